mips_debug_controller: RTL and testbench

Sequencer between a byte-stream command link (UART-style rx/tx) and the MIPS pipeline's debug/step ports. Decodes single-byte commands, gates the pipeline's step enable (free run or one cycle at a time), and walks the debug read ports to stream PC, register file and data memory contents back over the tx link. Sits at the top level, driving the pipeline's `i_step`, `i_debug_mips_register_number` and `i_debug_address`.

---
 rtl/mips_debug_controller.sv | 199 +++++++++++++++++++
 tb/tb_mips_debug_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_controller.sv
// Debug sequencer between a byte command link and the MIPS debug/step ports.
// Define MIPS_DEBUG_MEM_DUMP_EN to enable the 'm' data-memory dump command.
module mips_debug_controller #(
  parameter int unsigned NB              = 32,
  parameter int unsigned NB_BYTE         = 8,
  parameter int unsigned N_REGS          = 32,
  parameter int unsigned TAM_DATA_MEMORY = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_busy,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_step,
  output logic [4:0]         o_debug_mips_register_number,
  output logic [NB-1:0]      o_debug_address,
  input  logic [NB-1:0]      i_mips_pc,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic [NB-1:0]      i_mips_data_memory,
  input  logic               i_halt,
  output logic               o_busy
);

  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h63);
  localparam logic [NB_BYTE-1:0] CMD_PAUSE = NB_BYTE'(8'h70);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h73);
  localparam logic [NB_BYTE-1:0] CMD_REGS  = NB_BYTE'(8'h72);
  localparam logic [NB_BYTE-1:0] CMD_MEM   = NB_BYTE'(8'h6d);
  localparam logic [NB_BYTE-1:0] CMD_PC    = NB_BYTE'(8'h67);

  localparam int unsigned BYTES   = NB / NB_BYTE;
  localparam int unsigned CNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IDX_MAX = (N_REGS > TAM_DATA_MEMORY) ? N_REGS : TAM_DATA_MEMORY;
  localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  typedef enum logic [2:0] {
    StIdle, StRun, StStep, StLoad, StSend, StTxHold, StTxWait
  } state_e;

  typedef enum logic [1:0] {SrcPc, SrcReg, SrcMem} src_e;

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NB-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic [4:0]         reg_num_q, reg_num_d;
  logic [NB-1:0]      addr_q, addr_d;
  logic               last_word;

  always_comb begin
    unique case (src_q)
      SrcReg:  last_word = (idx_q == IDX_W'(N_REGS - 1));
      SrcMem:  last_word = (idx_q == IDX_W'(TAM_DATA_MEMORY - 1));
      default: last_word = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    reg_num_d  = reg_num_q;
    addr_d     = addr_q;

    case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_RUN:  state_d = StRun;
            CMD_STEP: state_d = StStep;
            CMD_PC: begin
              state_d = StLoad;
              src_d   = SrcPc;
              idx_d   = '0;
            end
            CMD_REGS: begin
              state_d = StLoad;
              src_d   = SrcReg;
              idx_d   = '0;
            end
`ifdef MIPS_DEBUG_MEM_DUMP_EN
            CMD_MEM: begin
              state_d = StLoad;
              src_d   = SrcMem;
              idx_d   = '0;
            end
`endif
            default: ;
          endcase
        end
      end
      StRun: begin
        if (i_halt || (i_rx_valid && i_rx_data == CMD_PAUSE)) state_d = StIdle;
      end
      StStep: begin
        state_d = StLoad;
        src_d   = SrcPc;
        idx_d   = '0;
      end
      StLoad: begin
        // Debug reads are combinational: select was registered last cycle, data is valid now.
        unique case (src_q)
          SrcReg:  shift_d = i_mips_register_data;
`ifdef MIPS_DEBUG_MEM_DUMP_EN
          SrcMem:  shift_d = i_mips_data_memory;
`endif
          default: shift_d = i_mips_pc;
        endcase
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (!i_tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = shift_q[NB-1 -: NB_BYTE];
          state_d    = StTxHold;
        end
      end
      StTxHold: state_d = StTxWait;
      StTxWait: begin
        if (!i_tx_busy) begin
          shift_d = shift_q << NB_BYTE;
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            if (last_word) begin
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StLoad;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StLoad && src_d == SrcReg) reg_num_d = 5'(idx_d);
    if (state_d == StLoad && src_d == SrcMem) addr_d = NB'(idx_d) << 2;
  end

  assign step_d = (state_d == StRun) || (state_d == StStep);
  assign busy_d = (state_d != StIdle);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      src_q      <= SrcPc;
      idx_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      reg_num_q  <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      reg_num_q  <= reg_num_d;
      addr_q     <= addr_d;
    end
  end

  assign o_tx_data                    = tx_data_q;
  assign o_tx_start                   = tx_start_q;
  assign o_step                       = step_q;
  assign o_busy                       = busy_q;
  assign o_debug_mips_register_number = reg_num_q;

`ifdef MIPS_DEBUG_MEM_DUMP_EN
  assign o_debug_address = addr_q;
`else
  logic unused_mem;
  assign unused_mem      = ^{i_mips_data_memory, addr_q};
  assign o_debug_address = '0;
`endif

endmodule

// File: tb/tb_mips_debug_controller.sv
// Self-checking bench for mips_debug_controller: pipeline/transmitter models plus a
// scoreboard of expected tx bytes checked on every o_tx_start.
module tb_mips_debug_controller;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        step;
  logic [4:0]  reg_num;
  logic [31:0] dbg_addr;
  logic [31:0] pc = 32'd0;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic        halt = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int step_cnt = 0;
  int tx_total = 0;
  int first_step_cyc = -1;
  int first_start_cyc = -1;
  int tx_busy_cnt = 0;
  logic prev_start = 1'b0;
  logic [7:0] exp_q[$];

  mips_debug_controller dut (
    .i_clk                        (i_clk),
    .i_reset                      (i_reset),
    .i_rx_data                    (rx_data),
    .i_rx_valid                   (rx_valid),
    .i_tx_busy                    (tx_busy),
    .o_tx_data                    (tx_data),
    .o_tx_start                   (tx_start),
    .o_step                       (step),
    .o_debug_mips_register_number (reg_num),
    .o_debug_address              (dbg_addr),
    .i_mips_pc                    (pc),
    .i_mips_register_data         (reg_data),
    .i_mips_data_memory           (mem_data),
    .i_halt                       (halt),
    .o_busy                       (busy)
  );

  always #5 i_clk = ~i_clk;

  // Pipeline model: register k holds k, memory word i holds i, PC advances 4 per step.
  assign reg_data = {27'd0, reg_num};
  assign mem_data = dbg_addr >> 2;
  assign tx_busy  = (tx_busy_cnt != 0);

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (step) pc <= pc + 32'd4;
    if (tx_start) tx_busy_cnt <= 5;
    else if (tx_busy_cnt > 0) tx_busy_cnt <= tx_busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: transmit protocol and byte stream against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (step) begin
        step_cnt++;
        if (first_step_cyc < 0) first_step_cyc = cyc;
        check("busy_while_step", {31'd0, busy}, 32'd1);
      end
      if (tx_start) begin
        tx_total++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
        check("tx_start_back_to_back", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx_byte: got %0h, expected none", tx_data);
        end else begin
          check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    prev_start = tx_start;
  end

  task automatic send_byte(input logic [7:0] b, output int k);
    @(posedge i_clk);
    #1;
    k = cyc;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_halt(output int k);
    @(posedge i_clk);
    #1;
    k = cyc;
    halt = 1'b1;
    @(posedge i_clk);
    #1;
    halt = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    repeat (2) @(negedge i_clk);
    while (busy && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({name, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({name, "_step"}, {31'd0, step}, 32'd0);
    check({name, "_reg_num"}, {27'd0, reg_num}, 32'd0);
    check({name, "_addr"}, dbg_addr, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k, m, base, base_tx, n;
    logic seen_busy;

    // Reset held two cycles.
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("in_reset");
    i_reset = 1'b0;
    @(negedge i_clk);
    check_all_zero("after_reset");

    // Unknown byte ignored.
    send_byte(8'h78, k);
    repeat (10) @(negedge i_clk);
    check("x_no_step", step_cnt, 0);
    check("x_no_tx", tx_total, 0);
    check("x_busy", {31'd0, busy}, 32'd0);

    // Single step: one step pulse, then PC (now 4) sent MSB first.
    first_step_cyc  = -1;
    first_start_cyc = -1;
    base = step_cnt;
    base_tx = tx_total;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    send_byte(8'h73, k);
    wait_idle(200, "step_timeout");
    check("step_count", step_cnt - base, 1);
    check("step_cycle", first_step_cyc, k + 1);
    check("step_tx_latency", {31'd0, first_start_cyc >= k + 4}, 32'd1);
    check("step_tx_count", tx_total - base_tx, 4);
    check("step_queue_empty", exp_q.size(), 0);

    // Run then pause 10 cycles later.
    base = step_cnt;
    send_byte(8'h63, k);
    repeat (8) @(posedge i_clk);
    send_byte(8'h70, m);
    @(negedge i_clk);
    check("pause_step_low", {31'd0, step}, 32'd0);
    check("pause_busy_low", {31'd0, busy}, 32'd0);
    check("run_pause_steps", step_cnt - base, 10);

    // Run then halt after 5 steps.
    base = step_cnt;
    send_byte(8'h63, k);
    repeat (3) @(posedge i_clk);
    pulse_halt(m);
    @(negedge i_clk);
    check("halt_step_low", {31'd0, step}, 32'd0);
    check("halt_busy_low", {31'd0, busy}, 32'd0);
    check("run_halt_steps", step_cnt - base, 5);

    // Register dump.
    base_tx = tx_total;
    for (int r = 0; r < 32; r++) push_word(32'(r));
    send_byte(8'h72, k);
    wait_idle(3000, "regs_timeout");
    check("regs_tx_count", tx_total - base_tx, 128);
    check("regs_queue_empty", exp_q.size(), 0);
    check("regs_last_select", {27'd0, reg_num}, 32'd31);

    // Memory dump.
    base_tx = tx_total;
`ifdef MIPS_DEBUG_MEM_DUMP_EN
    for (int i = 0; i < 16; i++) push_word(32'(i));
    send_byte(8'h6d, k);
    wait_idle(2000, "mem_timeout");
    check("mem_tx_count", tx_total - base_tx, 64);
    check("mem_queue_empty", exp_q.size(), 0);
    check("mem_last_addr", dbg_addr, 32'd60);
`else
    seen_busy = 1'b0;
    send_byte(8'h6d, k);
    repeat (20) begin
      @(negedge i_clk);
      if (busy) seen_busy = 1'b1;
    end
    check("mem_disabled_busy", {31'd0, seen_busy}, 32'd0);
    check("mem_disabled_tx", tx_total - base_tx, 0);
    check("mem_disabled_addr", dbg_addr, 32'd0);
`endif

    // Reset during register dump at word 10.
    for (int r = 0; r < 32; r++) push_word(32'(r));
    base_tx = tx_total;
    send_byte(8'h72, k);
    n = 0;
    while ((tx_total - base_tx) < 40 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check("abort_reached_word10", {31'd0, (tx_total - base_tx) >= 40}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("abort_tx_start", {31'd0, tx_start}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_reg_num", {27'd0, reg_num}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check("abort_no_resume", {31'd0, busy}, 32'd0);

    // PC reply after abort: 1 + 10 + 5 steps so far -> 0x40.
    base_tx = tx_total;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h40);
    send_byte(8'h67, k);
    wait_idle(200, "pc_timeout");
    check("pc_tx_count", tx_total - base_tx, 4);
    check("pc_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
